// File: rtl/press_decoder.sv
// Classifies press pulses into single/double/triple events by gap timing
// and queues them in a 4-entry FIFO with a sticky overflow flag.
module press_decoder #(
  parameter logic [24:0] GAP_CYCLES = 25'd30_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       press,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic [2:0] evt_count,
  output logic       overflow
);

  localparam int unsigned TIMER_W = 25;
  localparam int unsigned CODE_W  = 2;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned DEPTH   = 4;
  localparam logic [TIMER_W-1:0] GAP_LAST = GAP_CYCLES - TIMER_W'(1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t              state, state_n;
  logic [1:0]          cnt, cnt_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic                push_q, push_n;
  logic [CODE_W-1:0]   push_code_q, push_code_n;

  logic [CODE_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CNT_W-1:0]    count_n;
  logic [CODE_W-1:0]   head_n;
  logic                pop_c, full_c, wr_en_c, ovf_set_c;

  // Classifier state; the push request is registered so the FIFO sees it one edge later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      timer       <= '0;
      push_q      <= 1'b0;
      push_code_q <= 2'b00;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      timer       <= timer_n;
      push_q      <= push_n;
      push_code_q <= push_code_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    timer_n     = timer;
    push_n      = 1'b0;
    push_code_n = 2'b00;
    case (state)
      IDLE: begin
        if (press) begin
          state_n = COUNT;
          cnt_n   = 2'd1;
          timer_n = '0;
        end
      end
      COUNT: begin
        if (press) begin
          if (cnt == 2'd2) begin
            // third press closes the group without waiting for the gap
            push_n      = 1'b1;
            push_code_n = 2'b11;
            state_n     = IDLE;
            cnt_n       = 2'd0;
            timer_n     = '0;
          end else begin
            cnt_n   = cnt + 2'd1;
            timer_n = '0;
          end
        end else if (timer == GAP_LAST) begin
          push_n      = 1'b1;
          push_code_n = cnt;
          state_n     = IDLE;
          cnt_n       = 2'd0;
          timer_n     = '0;
        end else begin
          timer_n = timer + TIMER_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FIFO next-state; a push when full is only accepted if a pop frees a slot
  always_comb begin
    pop_c     = evt_valid & evt_ready;
    full_c    = (evt_count == CNT_W'(DEPTH));
    wr_en_c   = push_q & (~full_c | pop_c);
    ovf_set_c = push_q & full_c & ~pop_c;
    wr_ptr_n  = wr_en_c ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_n  = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_n   = evt_count;
    if (wr_en_c && !pop_c) begin
      count_n = evt_count + CNT_W'(1);
    end else if (!wr_en_c && pop_c) begin
      count_n = evt_count - CNT_W'(1);
    end
    // the entry being written this edge may become the new head
    head_n = (wr_en_c && (wr_ptr == rd_ptr_n)) ? push_code_q : mem[rd_ptr_n];
    if (count_n == '0) begin
      head_n = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 2'b00;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
      evt_valid <= 1'b0;
      evt_code  <= 2'b00;
      overflow  <= 1'b0;
    end else begin
      if (wr_en_c) begin
        mem[wr_ptr] <= push_code_q;
      end
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      evt_count <= count_n;
      evt_valid <= (count_n != '0);
      evt_code  <= head_n;
      overflow  <= overflow | ovf_set_c;
    end
  end

endmodule

// File: tb/tb_press_decoder.sv
// Directed bench for press_decoder with GAP_CYCLES=16: vector table for a
// triple-press group plus hand sequences for timing, overflow and reset.
module tb_press_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       press;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic [2:0] evt_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       press;
    logic       ready;
    logic       valid;
    logic [1:0] code;
    logic [2:0] count;
    logic       ovf;
  } vec_t;

  vec_t vec [13];

  press_decoder #(.GAP_CYCLES(25'd16)) dut (
    .clk       (clk),
    .rst       (rst),
    .press     (press),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_count (evt_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_once();
    press = 1'b1;
    step();
    press = 1'b0;
  endtask

  task automatic check_outputs(input string name, input logic v, input logic [1:0] c,
                               input logic [2:0] n, input logic o);
    check({name, ".valid"}, 32'(evt_valid), 32'(v));
    check({name, ".code"},  32'(evt_code),  32'(c));
    check({name, ".count"}, 32'(evt_count), 32'(n));
    check({name, ".ovf"},   32'(overflow),  32'(o));
  endtask

  // Event must appear exactly n edges after the current point, then pop (ready=1)
  task automatic expect_event(input int n, input logic [1:0] code, input string name);
    for (int i = 1; i < n; i++) begin
      step();
      check({name, ".early"}, 32'(evt_valid), 32'd0);
    end
    step();
    check({name, ".valid"}, 32'(evt_valid), 32'd1);
    check({name, ".code"},  32'(evt_code),  32'(code));
    step();
    check({name, ".popped"}, 32'(evt_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    press     = 1'b0;
    evt_ready = 1'b1;
    rst       = 1'b1;
    #2;
    check_outputs("reset_async", 1'b0, 2'b00, 3'd0, 1'b0);
    step();
    step();
    rst = 1'b0;
    check_outputs("reset", 1'b0, 2'b00, 3'd0, 1'b0);

    // Triple group: presses on rows 0, 5, 10; event visible one edge after the third
    for (int i = 0; i < 13; i++) vec[i] = '{1'b0, 1'b1, 1'b0, 2'b00, 3'd0, 1'b0};
    vec[0].press = 1'b1;
    vec[5].press = 1'b1;
    vec[10].press = 1'b1;
    vec[11].valid = 1'b1;
    vec[11].code  = 2'b11;
    vec[11].count = 3'd1;
    for (int i = 0; i < 13; i++) begin
      press     = vec[i].press;
      evt_ready = vec[i].ready;
      step();
      check_outputs($sformatf("triple[%0d]", i), vec[i].valid, vec[i].code,
                    vec[i].count, vec[i].ovf);
    end
    press     = 1'b0;
    evt_ready = 1'b1;

    // Single: valid 17 edges after the press edge
    press_once();
    expect_event(17, 2'b01, "single");

    // Double: second press 5 cycles after the first
    press_once();
    repeat (4) step();
    press_once();
    expect_event(17, 2'b10, "double");

    // Boundary: second press lands when timer=15 -> no single, double instead
    press_once();
    repeat (15) step();
    press_once();
    expect_event(17, 2'b10, "boundary");

    // Overflow: five singles with no consumer
    evt_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      press_once();
      repeat (20) step();
    end
    check_outputs("ovf_full", 1'b1, 2'b01, 3'd4, 1'b1);
    evt_ready = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      step();
      check($sformatf("ovf_drain%0d.count", k), 32'(evt_count), 32'(k));
    end
    step();
    check_outputs("ovf_drained", 1'b0, 2'b00, 3'd0, 1'b1);

    do_reset();
    check_outputs("reset2", 1'b0, 2'b00, 3'd0, 1'b0);

    // Full plus simultaneous pop: 4 singles queued, then a double pushed with ready=1
    evt_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      press_once();
      repeat (20) step();
    end
    check_outputs("full4", 1'b1, 2'b01, 3'd4, 1'b0);
    press_once();
    repeat (4) step();
    press_once();
    repeat (16) step();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check_outputs("simul", 1'b1, 2'b01, 3'd4, 1'b0);
    evt_ready = 1'b1;
    step();
    check_outputs("simul_pop1", 1'b1, 2'b01, 3'd3, 1'b0);
    step();
    check_outputs("simul_pop2", 1'b1, 2'b01, 3'd2, 1'b0);
    step();
    check_outputs("simul_tail", 1'b1, 2'b10, 3'd1, 1'b0);
    step();
    check_outputs("simul_empty", 1'b0, 2'b00, 3'd0, 1'b0);

    // Reset mid-operation: two events queued, FSM in COUNT
    evt_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      press_once();
      repeat (20) step();
    end
    check_outputs("pre_rst", 1'b1, 2'b01, 3'd2, 1'b0);
    press_once();
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    check_outputs("rst_async", 1'b0, 2'b00, 3'd0, 1'b0);
    step();
    press = 1'b1;
    step();
    rst   = 1'b0;
    press = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      check("post_rst.quiet", 32'(evt_valid), 32'd0);
    end
    press_once();
    expect_event(17, 2'b01, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
